// File: rtl/fms_share_arbiter.sv
// Round-robin arbiter and tag tracker that shares one pipelined fused
// multiply-subtract unit among NUM_REQ requesters.
`default_nettype none

module fms_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FMS_LATENCY = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*32-1:0]        req_a,
  input  logic [NUM_REQ*32-1:0]        req_b,
  input  logic [NUM_REQ*32-1:0]        req_c,
  output logic [31:0]                  fms_value1,
  output logic [31:0]                  fms_value2,
  output logic [31:0]                  fms_value3,
  input  logic [31:0]                  fms_result,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [31:0]                  rsp_data,
  output logic [$clog2(FMS_LATENCY+1)-1:0] inflight
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FMS_LATENCY + 1);

  logic [IDW-1:0]         last_grant;
  logic [IDW-1:0]         winner;
  logic                   found;
  logic                   grant;
  logic [FMS_LATENCY-1:0] tag_vld;
  logic [IDW-1:0]         tag_id [FMS_LATENCY];

  // Search starts just after the previous winner and wraps around.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign grant = found && !areset;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      last_grant <= IDW'(NUM_REQ - 1);
      fms_value1 <= '0;
      fms_value2 <= '0;
      fms_value3 <= '0;
    end else if (grant) begin
      last_grant <= winner;
      fms_value1 <= req_a[int'(winner)*32 +: 32];
      fms_value2 <= req_b[int'(winner)*32 +: 32];
      fms_value3 <= req_c[int'(winner)*32 +: 32];
    end
  end

  // Valid bits are cleared on reset so in-flight results are dropped.
  always_ff @(posedge aclk) begin
    if (areset) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= grant;
      for (int k = 1; k < FMS_LATENCY; k++) tag_vld[k] <= tag_vld[k-1];
    end
  end

  always_ff @(posedge aclk) begin
    tag_id[0] <= winner;
    for (int k = 1; k < FMS_LATENCY; k++) tag_id[k] <= tag_id[k-1];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rsp_valid <= '0;
      inflight  <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_vld[FMS_LATENCY-1]) rsp_valid[tag_id[FMS_LATENCY-1]] <= 1'b1;
      case ({grant, tag_vld[FMS_LATENCY-1]})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign rsp_data = fms_result;

endmodule

`default_nettype wire

// File: doc/fms_share_arbiter.md
# fms_share_arbiter

Round-robin arbiter and tag tracker that shares one pipelined fused multiply-subtract unit (result = value1 × value2 − value3, IEEE-754 single precision) among NUM_REQ requesters. It issues at most one operation per cycle and drives the unit's operand inputs from registers. A tag delay line matched to the unit's fixed latency routes each result back to the requester that issued it. It sits between requesting compute lanes and the single fpFuseMultSub instance.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- FMS_LATENCY, 8: fixed latency of the shared unit, in edges, from operands applied to result valid (1..32).
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  reset, synchronous and active-high.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester grant; combinational from req_valid and the arbiter pointer.
- req_a, req_b, req_c  in  NUM_REQ×32 each  packed operands; requester i uses bits [32i+31:32i].
- fms_value1, fms_value2, fms_value3  out  32 each  registered operands to the shared unit.
- fms_result  in  32  result from the shared unit.
- rsp_valid  out  NUM_REQ  one-hot pulse marking the owner of the current rsp_data.
- rsp_data  out  32  equals fms_result; meaningful only while rsp_valid is non-zero.
- inflight  out  $clog2(FMS_LATENCY+1)  number of operations issued but not yet returned.

## Operation
- Arbitration:
  - At most one req_ready bit is high per cycle.
  - The winner is the first requester with req_valid high, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - last_grant resets to NUM_REQ−1, so requester 0 has first priority after reset.
  - last_grant updates only on a cycle that has a grant.
- Handshake: a transfer occurs on an edge where req_valid[i] and req_ready[i] are both high.
  - No backpressure exists on responses; requesters must accept rsp_valid unconditionally.
  - A requester may hold req_valid high continuously. It is then re-granted in round-robin turn.
- Issue: on a transfer edge, fms_value1/2/3 load req_a/b/c of the winner.
  - With no transfer, the operand registers hold their value. The unit output for those cycles is untagged and ignored.
- Tag line: FMS_LATENCY stages, each holding {valid, id}.
  - Stage 1 loads {transfer, winner id} every edge.
  - Stage k loads stage k−1 every edge.
  - rsp_valid = decode(stage FMS_LATENCY) when that stage is valid; otherwise 0.
- inflight:
  - +1 on a transfer edge.
  - −1 on an edge where stage FMS_LATENCY is valid.
  - Both on the same edge: no change.
  - Never exceeds FMS_LATENCY.
- Reset values: fms_value1/2/3 = 0, all tag stages invalid, rsp_valid = 0, inflight = 0, last_grant = NUM_REQ−1. req_ready = 0 while areset is high.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid follows for them. Results still emerging from the unit are ignored.

## Timing
- A transfer at edge E drives operands after E. rsp_valid for that operation is high for exactly one cycle, after edge E+FMS_LATENCY.
- Full throughput: one transfer per cycle. Back-to-back transfers produce back-to-back responses in issue order.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once in every NUM_REQ consecutive cycles.
- req_ready depends combinationally on req_valid. Requesters must not derive req_valid from req_ready.
- A single requester alone gets a grant every cycle.

## Test plan
- Single op: requester 0 issues a=0x3FC00000, b=0x3FC00000, c=0x40200000 -> req_ready[0] high that cycle; fms_value* match after the edge; rsp_valid=4'b0001 with rsp_data=0xBE800000 exactly FMS_LATENCY edges later; inflight goes 1 then back to 0.
- Tag routing: requester 2 issues 0xC0600000, 0x40200000, 0x3FC00000, then requester 1 issues the test-1 operands on the next cycle -> rsp_valid=4'b0100 with 0xC1240000, then 4'b0010 with 0xBE800000 on consecutive cycles.
- Round robin: all four requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 responses return in the same order; inflight saturates at FMS_LATENCY=8 with no overflow.
- Sparse requests: only requesters 3 and 1 valid -> grants alternate 3,1,3,1 with wrap-around from 3 to 1; no grant to idle requesters.
- Reset mid-flight: issue 3 ops, assert areset one edge later -> no rsp_valid for the following 2×FMS_LATENCY cycles; inflight=0; first grant after release goes to requester 0.
- Idle stability: no requests for 20 cycles -> fms_value* hold their last values, rsp_valid=0, inflight=0.
